i2c_arbiter: RTL and testbench

I2C_ARBITER -- requirements
Module: i2c_arbiter

---
 rtl/i2c_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 34 +++
 rtl/i2c_arbiter.sv | 133 +++++++++++++
 tb/tb_i2c_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master arbiter: master state codes,
// arbiter FSM encoding and a one-hot to index helper.
package i2c_pkg;

  typedef enum logic [2:0] {
    M_IDLE       = 3'd0,
    M_ADDRESSING = 3'd1,
    M_WAITING    = 3'd2,
    M_READING    = 3'd3,
    M_WRITING    = 3'd4,
    M_DONE       = 3'd5
  } m_state_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RECOVER = 2'd2
  } arb_state_e;

  localparam int MAX_REQ = 8;

  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N_REQ.
module rr_arbiter
  import i2c_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] winner,
  output logic             valid
);

  logic             w_found;
  logic [PTR_W-1:0] w_idx;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    winner  = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = PTR_W'((int'(ptr) + k) % N_REQ);
      if (!w_found && req[w_idx]) begin
        winner[w_idx] = 1'b1;
        w_found       = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master between N_REQ requesters,
// with a RUN watchdog and a post-transaction master reset window.
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1024,
  parameter int RECOVER = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_rw,
  input  logic [8*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [N_REQ-1:0]   err,
  output logic [7:0]         rdata,
  output logic               busy,
  output logic               m_rst,
  output logic               m_rw,
  output logic [7:0]         m_data_in,
  input  logic [2:0]         m_state,
  input  logic [7:0]         m_data_out
);

  localparam int          PTR_W        = $clog2(N_REQ);
  localparam logic [15:0] TIMER_LAST   = 16'(TIMEOUT - 1);
  localparam logic [15:0] RECOVER_LAST = 16'(RECOVER - 1);

  arb_state_e       r_state, w_state_nxt;
  logic [N_REQ-1:0] r_owner, w_winner;
  logic             w_valid;
  logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
  logic [2:0]       w_win_idx;
  logic [15:0]      r_timer;
  logic             r_m_rw;
  logic [7:0]       r_m_data_in, r_rdata, w_wdata;
  logic             r_done_flag, r_err_flag;
  logic             w_m_done, w_timeout, w_recover_end;

  rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_rr (
    .req    (req),
    .ptr    (r_ptr),
    .winner (w_winner),
    .valid  (w_valid)
  );

  assign w_win_idx     = onehot_to_idx(MAX_REQ'(w_winner));
  assign w_ptr_nxt     = PTR_W'((int'(w_win_idx) + 1) % N_REQ);
  assign w_m_done      = (m_state == M_DONE);
  assign w_timeout     = (r_timer == TIMER_LAST);
  assign w_recover_end = (r_timer == RECOVER_LAST);

  always_comb begin
    w_wdata = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_winner[i]) w_wdata = req_wdata[8*i +: 8];
    end
  end

  // NOTE: sequential state uses <= so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_valid) w_state_nxt = ST_RUN;
      ST_RUN:     if (w_m_done || w_timeout) w_state_nxt = ST_RECOVER;
      ST_RECOVER: if (w_recover_end) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Grant and master reset are pure state decodes; pulses reuse the owner mask.
  always_comb begin
    busy  = (r_state != ST_IDLE);
    m_rst = (r_state != ST_RUN);
    gnt   = (r_state == ST_RUN) ? r_owner : '0;
    done  = r_done_flag ? r_owner : '0;
    err   = r_err_flag  ? r_owner : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_owner     <= '0;
      r_ptr       <= '0;
      r_timer     <= 16'd0;
      r_m_rw      <= 1'b1;
      r_m_data_in <= 8'h00;
      r_rdata     <= 8'h00;
      r_done_flag <= 1'b0;
      r_err_flag  <= 1'b0;
    end else begin
      r_done_flag <= 1'b0;
      r_err_flag  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_timer <= 16'd0;
          if (w_valid) begin
            r_owner     <= w_winner;
            r_m_rw      <= |(req_rw & w_winner);
            r_m_data_in <= w_wdata;
            r_ptr       <= w_ptr_nxt;
          end
        end
        ST_RUN: begin
          // DONE takes priority over a coincident timeout.
          if (w_m_done) begin
            r_done_flag <= 1'b1;
            r_timer     <= 16'd0;
            if (r_m_rw) r_rdata <= m_data_out;
          end else if (w_timeout) begin
            r_err_flag <= 1'b1;
            r_timer    <= 16'd0;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        ST_RECOVER: r_timer <= w_recover_end ? 16'd0 : r_timer + 16'd1;
        default:    r_timer <= 16'd0;
      endcase
    end
  end

  assign rdata     = r_rdata;
  assign m_rw      = r_m_rw;
  assign m_data_in = r_m_data_in;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Self-checking bench for i2c_arbiter: table of transactions with a queue
// scoreboard, plus a hand-written reset-during-RUN sequence.
module tb_i2c_arbiter;

  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 1024;
  localparam int RECOVER = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, req_rw;
  logic [31:0] req_wdata;
  logic [3:0]  gnt, done, err;
  logic [7:0]  rdata, m_data_in, m_data_out;
  logic        busy, m_rst, m_rw;
  logic [2:0]  m_state;

  always #5 clk = ~clk;

  i2c_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT), .RECOVER(RECOVER)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_rw     (req_rw),
    .req_wdata  (req_wdata),
    .gnt        (gnt),
    .done       (done),
    .err        (err),
    .rdata      (rdata),
    .busy       (busy),
    .m_rst      (m_rst),
    .m_rw       (m_rw),
    .m_data_in  (m_data_in),
    .m_state    (m_state),
    .m_data_out (m_data_out)
  );

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  rw;
    logic [31:0] wdata;
    bit          drop;       // release the winner's req right after grant
    int          delay;      // RUN cycle in which the master shows DONE, -1 = never
    logic [7:0]  mdata;
    logic [3:0]  exp_gnt;
    logic        exp_rw;
    logic [7:0]  exp_wdata;
    bit          exp_done;   // 0 = expect err pulse instead
    logic [7:0]  exp_rdata;
    int          exp_lat;    // cycles from first grant cycle to pulse
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic [3:0] done_v;
    logic [3:0] err_v;
    logic [7:0] rdata;
    int         lat;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_gnt"},       32'(gnt),       32'h0);
    check({tag, "_done"},      32'(done),      32'h0);
    check({tag, "_err"},       32'(err),       32'h0);
    check({tag, "_rdata"},     32'(rdata),     32'h0);
    check({tag, "_busy"},      32'(busy),      32'h0);
    check({tag, "_m_rst"},     32'(m_rst),     32'h1);
    check({tag, "_m_rw"},      32'(m_rw),      32'h1);
    check({tag, "_m_data_in"}, 32'(m_data_in), 32'h0);
  endtask

  // Called at a negedge while the arbiter is IDLE; returns at the first IDLE
  // cycle after the RECOVER window.
  task automatic run_txn(input vec_t v);
    exp_t e;
    bit   got;
    bit   run_ok;
    int   cyc;
    req       = v.req;
    req_rw    = v.rw;
    req_wdata = v.wdata;
    m_state   = 3'd0;
    e.gnt     = v.exp_gnt;
    e.done_v  = v.exp_done ? v.exp_gnt : 4'h0;
    e.err_v   = v.exp_done ? 4'h0 : v.exp_gnt;
    e.rdata   = v.exp_rdata;
    e.lat     = v.exp_lat;
    sb.push_back(e);

    got = 1'b0;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      if (gnt != 4'h0) got = 1'b1;
    end
    check("grant", 32'(gnt), 32'(v.exp_gnt));
    check("m_rw", 32'(m_rw), 32'(v.exp_rw));
    check("m_data_in", 32'(m_data_in), 32'(v.exp_wdata));
    check("m_rst_run", 32'(m_rst), 32'h0);
    if (!got) begin
      e = sb.pop_front();
      return;
    end

    if (v.drop) req = req & ~v.exp_gnt;
    req_rw    = ~req_rw;
    req_wdata = ~req_wdata;
    cyc    = 0;
    got    = 1'b0;
    run_ok = 1'b1;
    while (!got && cyc < TIMEOUT + 64) begin
      if (cyc == v.delay) begin
        m_state    = 3'd5;
        m_data_out = v.mdata;
      end else begin
        m_state    = 3'(1 + cyc % 4);
        m_data_out = 8'(cyc * 7);
      end
      @(negedge clk);
      cyc++;
      if (done != 4'h0 || err != 4'h0) got = 1'b1;
      else if (gnt != v.exp_gnt || m_rw != v.exp_rw || m_data_in != v.exp_wdata ||
               m_rst != 1'b0 || busy != 1'b1) run_ok = 1'b0;
    end
    m_state    = 3'd0;
    m_data_out = 8'h00;

    e = sb.pop_front();
    check("run_hold", 32'(run_ok), 32'h1);
    check("pulse_seen", 32'(got), 32'h1);
    check("latency", 32'(cyc), 32'(e.lat));
    check("done", 32'(done), 32'(e.done_v));
    check("err", 32'(err), 32'(e.err_v));
    check("rdata", 32'(rdata), 32'(e.rdata));
    check("gnt_clear", 32'(gnt), 32'h0);
    check("m_rst_rec", 32'(m_rst), 32'h1);
    @(negedge clk);
    check("recover", 32'({busy, m_rst, gnt, done, err}), 32'(14'b11_0000_0000_0000));
    @(negedge clk);
    check("idle", 32'({busy, m_rst}), 32'(2'b01));
  endtask

  initial begin
    // req, rw, wdata, drop, delay, mdata, exp_gnt, exp_rw, exp_wdata, exp_done, exp_rdata, exp_lat
    vecs[0] = '{4'b1111, 4'b1010, 32'hD4C3B2A1, 1'b0,    3, 8'h11, 4'b0001, 1'b0, 8'hA1, 1'b1, 8'h00,    4};
    vecs[1] = '{4'b1111, 4'b1010, 32'hD4C3B2A1, 1'b0,    5, 8'h5A, 4'b0010, 1'b1, 8'hB2, 1'b1, 8'h5A,    6};
    vecs[2] = '{4'b1111, 4'b1010, 32'hD4C3B2A1, 1'b0,    0, 8'h77, 4'b0100, 1'b0, 8'hC3, 1'b1, 8'h5A,    1};
    vecs[3] = '{4'b1111, 4'b1010, 32'hD4C3B2A1, 1'b0,    7, 8'hE1, 4'b1000, 1'b1, 8'hD4, 1'b1, 8'hE1,    8};
    vecs[4] = '{4'b1111, 4'b1010, 32'hD4C3B2A1, 1'b0,    2, 8'h99, 4'b0001, 1'b0, 8'hA1, 1'b1, 8'hE1,    3};
    vecs[5] = '{4'b0001, 4'b0001, 32'h44332211, 1'b0,   20, 8'hF6, 4'b0001, 1'b1, 8'h11, 1'b1, 8'hF6,   21};
    vecs[6] = '{4'b0010, 4'b0000, 32'h00005C00, 1'b1,    9, 8'h00, 4'b0010, 1'b0, 8'h5C, 1'b1, 8'hF6,   10};
    vecs[7] = '{4'b1011, 4'b1000, 32'h7E000000, 1'b0,    4, 8'h3C, 4'b1000, 1'b1, 8'h7E, 1'b1, 8'h3C,    5};
    vecs[8] = '{4'b0100, 4'b0000, 32'h00A50000, 1'b0,   -1, 8'h00, 4'b0100, 1'b0, 8'hA5, 1'b0, 8'h3C, 1024};
    vecs[9] = '{4'b0100, 4'b0100, 32'h00660000, 1'b0, 1023, 8'h42, 4'b0100, 1'b1, 8'h66, 1'b1, 8'h42, 1024};

    rst        = 1'b0;
    req        = 4'h0;
    req_rw     = 4'h0;
    req_wdata  = 32'h0;
    m_state    = 3'd0;
    m_data_out = 8'h00;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b1;

    for (int i = 0; i < 10; i++) run_txn(vecs[i]);

    // Reset in the middle of RUN, with DONE presented on the same edge.
    begin
      bit got;
      req       = 4'b0001;
      req_rw    = 4'b0000;
      req_wdata = 32'h000000C7;
      got = 1'b0;
      for (int i = 0; i < 16 && !got; i++) begin
        @(negedge clk);
        if (gnt != 4'h0) got = 1'b1;
      end
      check("mid_grant", 32'(gnt), 32'h1);
      repeat (5) @(negedge clk);
      rst        = 1'b0;
      m_state    = 3'd5;
      m_data_out = 8'hAB;
      @(negedge clk);
      check_reset("rst_mid");
      req     = 4'h0;
      m_state = 3'd0;
      @(negedge clk);
      check("rst_hold_pulses", 32'({done, err}), 32'h0);
      rst = 1'b1;
      @(negedge clk);
      check("post_rst", 32'({busy, done, err}), 32'h0);
      req = 4'b1111;
      @(negedge clk);
      check("post_rst_grant", 32'(gnt), 32'h1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 20000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
